ffe_win_ctrl: RTL

- Sequencing controller for the FFE tap-window stage, which builds a TOTAL_TAP-wide window from the post beat (current), the main beat (d1) and the pre beat (d2).
- Tracks beat validity through the two-deep delay line and drives its shift enable.
- Flags which windows are complete and masks missing pre/post taps at stream edges.
- Owns a shadow/active tap-coefficient bank; a commit swaps the banks only between streams.

---
 rtl/ffe_win_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/ffe_win_ctrl.sv
// ffe_win_ctrl: sequencing controller for the FFE tap-window stage.
// It follows beat validity through the two-deep delay line (d1, d2). From
// that it drives the delay-line shift enable, marks complete windows, and
// masks the pre/post taps that are missing at the stream edges. It also owns
// a shadow/active coefficient bank, and the bank swap only happens between
// streams.
module ffe_win_ctrl #(
  parameter int MAIN_TAP   = 2,
  parameter int PRE_TAP    = 1,
  parameter int POST_TAP   = 1,
  parameter int TOTAL_TAP  = 4,
  parameter int COEF_WIDTH = 8,
  parameter int ADDR_WIDTH = 2,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  input  logic                            in_last,
  output logic                            in_ready,
  output logic                            shift_en,
  output logic                            win_valid,
  output logic                            win_last,
  output logic                            pre_mask,
  output logic                            post_mask,
  output logic [LEN_WIDTH-1:0]            stream_len,
  input  logic                            cfg_wr_en,
  input  logic [ADDR_WIDTH-1:0]           cfg_addr,
  input  logic [COEF_WIDTH-1:0]           cfg_wr_data,
  input  logic                            cfg_commit,
  output logic                            cfg_pending,
  output logic                            cfg_err,
  output logic [TOTAL_TAP*COEF_WIDTH-1:0] coef_active
);

  // IDLE : nothing buffered; the first beat loads d1 and makes no window.
  // FIRST: d1 holds beat 0 and d2 is empty, so the next window lacks pre taps.
  // RUN  : d1 and d2 both hold beats, so every accepted beat completes a window.
  // DRAIN: the last beat sits in d1. One extra shift flushes the last window.
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FIRST = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  localparam int                   BANK_W      = TOTAL_TAP * COEF_WIDTH;
  localparam logic [31:0]          TOTAL_TAP_U = 32'(TOTAL_TAP);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE     = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0] LEN_MAX     = '1;

  // Refuse to elaborate with a window geometry or address width that cannot work
  if (PRE_TAP + MAIN_TAP + POST_TAP != TOTAL_TAP) begin : g_geom_bad
    $error("ffe_win_ctrl: PRE_TAP + MAIN_TAP + POST_TAP must equal TOTAL_TAP");
  end
  if ((2 ** ADDR_WIDTH) < TOTAL_TAP) begin : g_addr_bad
    $error("ffe_win_ctrl: ADDR_WIDTH too narrow to address TOTAL_TAP taps");
  end

  logic [1:0]           state_q, state_d;
  logic [LEN_WIDTH-1:0] stream_len_q, stream_len_d;
  logic [BANK_W-1:0]    shadow_q, shadow_d;
  logic [BANK_W-1:0]    coef_active_q, coef_active_d;
  logic                 cfg_pending_q, cfg_pending_d;
  logic                 cfg_err_q, cfg_err_d;

  logic                 accept;
  logic                 in_drain;
  logic [31:0]          cfg_addr_ext;
  logic                 wr_in_range;
  logic                 commit_apply;

  // Handshake and window flags are decoded with zero latency from the state and inputs
  always_comb begin
    in_drain  = (state_q == DRAIN);
    in_ready  = !in_drain;
    accept    = in_valid && !in_drain;
    shift_en  = accept || in_drain;
    win_valid = 1'b0;
    win_last  = 1'b0;
    pre_mask  = 1'b0;
    post_mask = 1'b0;
    case (state_q)
      FIRST: begin
        win_valid = accept;
        pre_mask  = accept;
      end
      RUN: begin
        win_valid = accept;
      end
      DRAIN: begin
        win_valid = 1'b1;
        win_last  = 1'b1;
        post_mask = 1'b1;
        pre_mask  = (stream_len_q == LEN_ONE);
      end
      default: begin
      end
    endcase
  end

  // Next state: advance on accepted beats; DRAIN always lasts exactly one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = in_last ? DRAIN : FIRST;
        end
      end
      FIRST, RUN: begin
        if (accept) begin
          state_d = in_last ? DRAIN : RUN;
        end
      end
      DRAIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Beat count: restart at 1 on a new stream, saturate, and hold between streams
  always_comb begin
    stream_len_d = stream_len_q;
    if (accept) begin
      if (state_q == IDLE) begin
        stream_len_d = LEN_ONE;
      end else if (stream_len_q != LEN_MAX) begin
        stream_len_d = stream_len_q + LEN_ONE;
      end
    end
  end

  // Shadow bank writes. Out-of-range addresses are dropped and latch a sticky error.
  always_comb begin
    cfg_addr_ext = 32'(cfg_addr);
    wr_in_range  = cfg_wr_en && (cfg_addr_ext < TOTAL_TAP_U);
    shadow_d     = shadow_q;
    for (int i = 0; i < TOTAL_TAP; i++) begin
      if (wr_in_range && (cfg_addr_ext == 32'(i))) begin
        shadow_d[i*COEF_WIDTH +: COEF_WIDTH] = cfg_wr_data;
      end
    end
    cfg_err_d = cfg_err_q || (cfg_wr_en && !wr_in_range);
  end

  // Commit: copy shadow (including a same-cycle write) to active only while IDLE
  always_comb begin
    commit_apply  = (state_q == IDLE) && (cfg_pending_q || cfg_commit);
    coef_active_d = coef_active_q;
    cfg_pending_d = cfg_pending_q || cfg_commit;
    if (commit_apply) begin
      coef_active_d = shadow_d;
      cfg_pending_d = 1'b0;
    end
  end

  // State and configuration registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      stream_len_q  <= '0;
      shadow_q      <= '0;
      coef_active_q <= '0;
      cfg_pending_q <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      stream_len_q  <= stream_len_d;
      shadow_q      <= shadow_d;
      coef_active_q <= coef_active_d;
      cfg_pending_q <= cfg_pending_d;
      cfg_err_q     <= cfg_err_d;
    end
  end

  assign stream_len  = stream_len_q;
  assign coef_active = coef_active_q;
  assign cfg_pending = cfg_pending_q;
  assign cfg_err     = cfg_err_q;

  // Structural invariants of the sequencing and the bank swap
  a_drain_one_cycle: assert property (@(posedge clk) disable iff (reset)
    (state_q == DRAIN) |=> (state_q == IDLE));
  a_last_is_window: assert property (@(posedge clk) disable iff (reset)
    win_last |-> (win_valid && post_mask && shift_en));
  a_bank_frozen_in_stream: assert property (@(posedge clk) disable iff (reset)
    (state_q != IDLE) |=> $stable(coef_active_q));
  a_err_sticky: assert property (@(posedge clk) disable iff (reset)
    cfg_err_q |=> cfg_err_q);

endmodule
